// File: rtl/bnn_param_loader.sv
// Parameter loader for the 8-8-4 BNN: nibble stream -> neuron {weight, threshold} writes.
// Define BNN_LOADER_CSUM_EN to require a trailing XOR checksum nibble per sequence.
module bnn_param_loader #(
    parameter int NUM_NEURONS = 20,
    parameter int IDX_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic             nib_valid,
    input  logic [3:0]       nib_data,
    output logic             nib_ready,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_idx,
    output logic [7:0]       wr_weight,
    output logic [3:0]       wr_thresh,
    output logic             busy,
    output logic             infer_hold,
    output logic             done,
    output logic             err
);

`ifdef BNN_LOADER_CSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_W_LO, S_W_HI, S_THR, S_COMMIT, S_DONE, S_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_W_LO, S_W_HI, S_THR, S_COMMIT, S_DONE
    } state_t;
`endif

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       lo_q, lo_d, hi_q, hi_d, thr_q, thr_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] wr_idx_q;
    logic [7:0]       wr_weight_q;
    logic [3:0]       wr_thresh_q;
    logic             rx_state, xfer, commit, done_c;
`ifdef BNN_LOADER_CSUM_EN
    logic [3:0]       csum_q, csum_d;
`endif

    always_comb begin
        rx_state = (state_q == S_W_LO) || (state_q == S_W_HI) || (state_q == S_THR);
`ifdef BNN_LOADER_CSUM_EN
        rx_state = rx_state || (state_q == S_CSUM);
`endif
    end

    assign nib_ready = ena & ~reset & rx_state;
    assign xfer      = nib_valid & nib_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        thr_d   = thr_q;
        err_d   = err_q;
        commit  = 1'b0;
        done_c  = 1'b0;
`ifdef BNN_LOADER_CSUM_EN
        csum_d  = csum_q;
        if (xfer && state_q != S_CSUM) csum_d = csum_q ^ nib_data;
`endif
        // abort outranks any transfer, commit or done in the same cycle
        if (ena && abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (ena) begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    state_d = S_W_LO;
                    idx_d   = '0;
                    err_d   = 1'b0;
`ifdef BNN_LOADER_CSUM_EN
                    csum_d  = '0;
`endif
                end
                S_W_LO: if (xfer) begin
                    lo_d    = nib_data;
                    state_d = S_W_HI;
                end
                S_W_HI: if (xfer) begin
                    hi_d    = nib_data;
                    state_d = S_THR;
                end
                S_THR: if (xfer) begin
                    thr_d   = nib_data;
                    state_d = S_COMMIT;
                end
                S_COMMIT: begin
                    commit = 1'b1;
                    if (idx_q == LAST) begin
`ifdef BNN_LOADER_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_W_LO;
                    end
                end
                S_DONE: begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef BNN_LOADER_CSUM_EN
                S_CSUM: if (xfer) begin
                    if (nib_data != csum_q) err_d = 1'b1;
                    state_d = S_DONE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            thr_q       <= '0;
            err_q       <= 1'b0;
            wr_idx_q    <= '0;
            wr_weight_q <= '0;
            wr_thresh_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            thr_q   <= thr_d;
            err_q   <= err_d;
            if (wr_en) begin
                wr_idx_q    <= idx_q;
                wr_weight_q <= {hi_q, lo_q};
                wr_thresh_q <= thr_q;
            end
        end
    end

`ifdef BNN_LOADER_CSUM_EN
    always_ff @(posedge clk) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end
`endif

    // record is visible during the commit cycle, then held until the next one
    assign wr_en      = commit & ~reset;
    assign wr_idx     = wr_en ? idx_q : wr_idx_q;
    assign wr_weight  = wr_en ? {hi_q, lo_q} : wr_weight_q;
    assign wr_thresh  = wr_en ? thr_q : wr_thresh_q;
    assign done       = done_c & ~reset;
    assign busy       = (state_q != S_IDLE);
    assign infer_hold = busy;
    assign err        = err_q;

endmodule
